// File: rtl/sdram_row_ctrl_if.sv
// Host and SDRAM-channel signal bundle for the row-tracking SDRAM controller.
// The master side drives requests and channel completions; the slave side is the controller.
interface sdram_row_ctrl_if;
  logic        host_req;
  logic        host_rnw;
  logic [21:0] host_addr;
  logic [31:0] host_din;
  logic [3:0]  host_be;
  logic        host_busy;
  logic [31:0] host_dout;
  logic        host_ack;
  logic [12:0] sd_caddr;
  logic        sd_req;
  logic        sd_act;
  logic        sd_pch;
  logic        sd_ref;
  logic        sd_rnw;
  logic [31:0] sd_din;
  logic [3:0]  sd_be;
  logic [31:0] sd_dout;
  logic        sd_ready;

  modport master (
    output host_req, host_rnw, host_addr, host_din, host_be, sd_dout, sd_ready,
    input  host_busy, host_dout, host_ack, sd_caddr, sd_req, sd_act, sd_pch, sd_ref,
           sd_rnw, sd_din, sd_be
  );

  modport slave (
    input  host_req, host_rnw, host_addr, host_din, host_be, sd_dout, sd_ready,
    output host_busy, host_dout, host_ack, sd_caddr, sd_req, sd_act, sd_pch, sd_ref,
           sd_rnw, sd_din, sd_be
  );
endinterface

// File: rtl/sdram_row_ctrl.sv
// Single-bank open-row SDRAM controller: tracks one open row, issues precharge/activate/access
// command pulses with fixed gaps, and inserts periodic refresh between host requests.
module sdram_row_ctrl #(
  parameter int REFRESH_CYCLES = 780,
  parameter int T_RP           = 3,
  parameter int T_RCD          = 3,
  parameter int T_RFC          = 10
) (
  input logic             clk,
  input logic             init,
  sdram_row_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PRECH, PWAIT, ACTV, AWAIT, ACCESS, REFR, RWAIT
  } state_t;

  localparam int WMAX_C = (T_RFC > T_RP) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                         : ((T_RP > T_RCD) ? T_RP : T_RCD);
  localparam int WW     = $clog2(WMAX_C + 1);
  localparam int RCW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  state_t          state_r;
  logic            row_open_r;
  logic [12:0]     open_row_r;
  logic [RCW-1:0]  refr_cnt_r;
  logic            refresh_pending_r;
  logic            refr_run_r;
  logic            req_valid_r;
  logic            rnw_r;
  logic [21:0]     addr_r;
  logic [31:0]     din_r;
  logic [3:0]      be_r;
  logic [WW-1:0]   wait_r;

  logic            due_s;
  logic            hit_s;
  logic            rnw_s;
  logic [21:0]     addr_s;
  logic [31:0]     din_s;
  logic [3:0]      be_s;

  assign due_s  = (refr_cnt_r == RCW'(REFRESH_CYCLES - 1));
  assign hit_s  = row_open_r && (bus.host_addr[21:9] == open_row_r);
  // In IDLE a command can be issued in the acceptance cycle, before the latches hold the request.
  assign rnw_s  = (state_r == IDLE) ? bus.host_rnw  : rnw_r;
  assign addr_s = (state_r == IDLE) ? bus.host_addr : addr_r;
  assign din_s  = (state_r == IDLE) ? bus.host_din  : din_r;
  assign be_s   = (state_r == IDLE) ? bus.host_be   : be_r;

  // Controller FSM, refresh timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (init) begin
      state_r           <= IDLE;
      row_open_r        <= 1'b0;
      open_row_r        <= 13'h0000;
      refr_cnt_r        <= '0;
      refresh_pending_r <= 1'b0;
      refr_run_r        <= 1'b0;
      req_valid_r       <= 1'b0;
      rnw_r             <= 1'b0;
      addr_r            <= 22'h000000;
      din_r             <= 32'h00000000;
      be_r              <= 4'b0000;
      wait_r            <= '0;
      bus.host_busy     <= 1'b0;
      bus.host_dout     <= 32'h00000000;
      bus.host_ack      <= 1'b0;
      bus.sd_caddr      <= 13'h0000;
      bus.sd_req        <= 1'b0;
      bus.sd_act        <= 1'b0;
      bus.sd_pch        <= 1'b0;
      bus.sd_ref        <= 1'b0;
      bus.sd_rnw        <= 1'b0;
      bus.sd_din        <= 32'h00000000;
      bus.sd_be         <= 4'b0000;
    end else begin
      bus.sd_req   <= 1'b0;
      bus.sd_act   <= 1'b0;
      bus.sd_pch   <= 1'b0;
      bus.sd_ref   <= 1'b0;
      bus.host_ack <= 1'b0;

      if (due_s) begin
        refr_cnt_r        <= '0;
        refresh_pending_r <= 1'b1;
      end else begin
        refr_cnt_r <= refr_cnt_r + RCW'(1);
      end

      if (wait_r != '0) begin
        wait_r <= wait_r - WW'(1);
      end else begin
        wait_r <= wait_r;
      end

      case (state_r)
        IDLE: begin
          if (refresh_pending_r) begin
            bus.host_busy <= 1'b1;
            refr_run_r    <= 1'b1;
            if (row_open_r) begin
              bus.sd_pch <= 1'b1;
              row_open_r <= 1'b0;
              wait_r     <= WW'(T_RP - 1);
              state_r    <= PRECH;
            end else begin
              bus.sd_ref <= 1'b1;
              wait_r     <= WW'(T_RFC - 1);
              state_r    <= REFR;
            end
          end else if (bus.host_req) begin
            req_valid_r   <= 1'b1;
            rnw_r         <= bus.host_rnw;
            addr_r        <= bus.host_addr;
            din_r         <= bus.host_din;
            be_r          <= bus.host_be;
            bus.host_busy <= 1'b1;
            // A refresh falling due now wins; the held request restarts from a closed row.
            if (due_s) begin
              state_r <= IDLE;
            end else if (hit_s) begin
              bus.sd_req   <= 1'b1;
              bus.sd_caddr <= {4'b0000, addr_s[8:0]};
              bus.sd_rnw   <= rnw_s;
              bus.sd_din   <= din_s;
              bus.sd_be    <= be_s;
              state_r      <= ACCESS;
            end else if (row_open_r) begin
              bus.sd_pch <= 1'b1;
              row_open_r <= 1'b0;
              wait_r     <= WW'(T_RP - 1);
              state_r    <= PRECH;
            end else begin
              bus.sd_act   <= 1'b1;
              bus.sd_caddr <= addr_s[21:9];
              row_open_r   <= 1'b1;
              open_row_r   <= addr_s[21:9];
              wait_r       <= WW'(T_RCD - 1);
              state_r      <= ACTV;
            end
          end else begin
            bus.host_busy <= due_s;
          end
        end
        PRECH, PWAIT: begin
          state_r <= PWAIT;
          if (wait_r == '0) begin
            if (refr_run_r) begin
              bus.sd_ref <= 1'b1;
              wait_r     <= WW'(T_RFC - 1);
              state_r    <= REFR;
            end else begin
              bus.sd_act   <= 1'b1;
              bus.sd_caddr <= addr_s[21:9];
              row_open_r   <= 1'b1;
              open_row_r   <= addr_s[21:9];
              wait_r       <= WW'(T_RCD - 1);
              state_r      <= ACTV;
            end
          end else begin
            state_r <= PWAIT;
          end
        end
        ACTV, AWAIT: begin
          if (wait_r == '0) begin
            bus.sd_req   <= 1'b1;
            bus.sd_caddr <= {4'b0000, addr_s[8:0]};
            bus.sd_rnw   <= rnw_s;
            bus.sd_din   <= din_s;
            bus.sd_be    <= be_s;
            state_r      <= ACCESS;
          end else begin
            state_r <= AWAIT;
          end
        end
        ACCESS: begin
          if (bus.sd_ready) begin
            if (rnw_r) begin
              bus.host_dout <= bus.sd_dout;
            end else begin
              bus.host_dout <= bus.host_dout;
            end
            bus.host_ack  <= 1'b1;
            req_valid_r   <= 1'b0;
            bus.host_busy <= refresh_pending_r | due_s;
            state_r       <= IDLE;
          end else begin
            state_r <= ACCESS;
          end
        end
        REFR, RWAIT: begin
          if (wait_r == '0) begin
            refresh_pending_r <= due_s;
            refr_run_r        <= 1'b0;
            row_open_r        <= 1'b0;
            if (req_valid_r) begin
              bus.sd_act   <= 1'b1;
              bus.sd_caddr <= addr_s[21:9];
              row_open_r   <= 1'b1;
              open_row_r   <= addr_s[21:9];
              wait_r       <= WW'(T_RCD - 1);
              state_r      <= ACTV;
            end else begin
              bus.host_busy <= due_s;
              state_r       <= IDLE;
            end
          end else begin
            state_r <= RWAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_row_ctrl.sv
// Directed bench for sdram_row_ctrl: row hit/miss/closed paths, periodic refresh,
// refresh colliding with a request, and abort by init during an access.
module tb_sdram_row_ctrl;
  logic clk = 1'b0;
  logic init;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   n_ack  = 0;
  int   n_act  = 0;
  int   n_pch  = 0;
  int   viol   = 0;
  int   prev_pulses = 0;
  int   pulses_s;

  always #5 clk = ~clk;

  sdram_row_ctrl_if bus ();
  sdram_row_ctrl dut (.clk(clk), .init(init), .bus(bus));

  assign pulses_s = int'(bus.sd_req) + int'(bus.sd_act) + int'(bus.sd_pch) + int'(bus.sd_ref);

  // Pulse counters and a watch for overlapping or back-to-back channel commands.
  always @(posedge clk) begin
    n_ack <= n_ack + int'(bus.host_ack);
    n_act <= n_act + int'(bus.sd_act);
    n_pch <= n_pch + int'(bus.sd_pch);
    if (pulses_s > 1 || (pulses_s > 0 && prev_pulses > 0)) viol <= viol + 1;
    prev_pulses <= pulses_s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input logic rnw, input logic [21:0] addr, input logic [31:0] din,
                       input logic [3:0] be);
    bus.host_req  = 1'b1;
    bus.host_rnw  = rnw;
    bus.host_addr = addr;
    bus.host_din  = din;
    bus.host_be   = be;
    step();
    bus.host_req  = 1'b0;
  endtask

  // Leaves the bench in the cycle where host_ack should be visible.
  task automatic complete(input logic [31:0] d);
    step();
    bus.sd_dout  = d;
    bus.sd_ready = 1'b1;
    step();
    bus.sd_ready = 1'b0;
  endtask

  initial begin
    int b_cyc;
    int n;
    int k;
    int pk;
    int rk;
    int ack0;
    int act0;
    int pch0;
    init          = 1'b1;
    bus.host_req  = 1'b0;
    bus.host_rnw  = 1'b0;
    bus.host_addr = 22'h000000;
    bus.host_din  = 32'h00000000;
    bus.host_be   = 4'b0000;
    bus.sd_dout   = 32'h00000000;
    bus.sd_ready  = 1'b0;
    steps(3);
    chk("rst_busy", {31'h0, bus.host_busy}, 32'h0);
    chk("rst_pulses", pulses_s, 32'h0);
    chk("rst_dout", bus.host_dout, 32'h0);
    chk("rst_caddr", {19'h0, bus.sd_caddr}, 32'h0);
    init = 1'b0;
    step();

    // Closed-row read
    issue(1'b1, {13'h0012, 9'h005}, 32'h0, 4'hF);
    chk("t1_act", {31'h0, bus.sd_act}, 32'h1);
    chk("t1_act_row", {19'h0, bus.sd_caddr}, 32'h0012);
    chk("t1_busy", {31'h0, bus.host_busy}, 32'h1);
    steps(2);
    chk("t1_req_early", {31'h0, bus.sd_req}, 32'h0);
    step();
    chk("t1_req", {31'h0, bus.sd_req}, 32'h1);
    chk("t1_req_col", {19'h0, bus.sd_caddr}, 32'h0005);
    chk("t1_rnw", {31'h0, bus.sd_rnw}, 32'h1);
    complete(32'hDEADBEEF);
    chk("t1_ack", {31'h0, bus.host_ack}, 32'h1);
    chk("t1_dout", bus.host_dout, 32'hDEADBEEF);
    chk("t1_busy_off", {31'h0, bus.host_busy}, 32'h0);
    step();
    chk("t1_ack_one", {31'h0, bus.host_ack}, 32'h0);

    // Row hit
    act0 = n_act; pch0 = n_pch;
    issue(1'b1, {13'h0012, 9'h006}, 32'h0, 4'hF);
    chk("t2_req", {31'h0, bus.sd_req}, 32'h1);
    chk("t2_col", {19'h0, bus.sd_caddr}, 32'h0006);
    complete(32'h12345678);
    chk("t2_ack", {31'h0, bus.host_ack}, 32'h1);
    chk("t2_dout", bus.host_dout, 32'h12345678);
    step();
    chk("t2_no_act", n_act - act0, 32'h0);
    chk("t2_no_pch", n_pch - pch0, 32'h0);

    // Row miss write
    issue(1'b0, {13'h0013, 9'h1AB}, 32'hCAFEF00D, 4'b0011);
    chk("t3_pch", {31'h0, bus.sd_pch}, 32'h1);
    steps(3);
    chk("t3_act", {31'h0, bus.sd_act}, 32'h1);
    chk("t3_act_row", {19'h0, bus.sd_caddr}, 32'h0013);
    steps(3);
    chk("t3_req", {31'h0, bus.sd_req}, 32'h1);
    chk("t3_col", {19'h0, bus.sd_caddr}, 32'h01AB);
    chk("t3_rnw", {31'h0, bus.sd_rnw}, 32'h0);
    chk("t3_be", {28'h0, bus.sd_be}, 32'h3);
    chk("t3_din", bus.sd_din, 32'hCAFEF00D);
    complete(32'hFFFFFFFF);
    chk("t3_ack", {31'h0, bus.host_ack}, 32'h1);
    chk("t3_dout_kept", bus.host_dout, 32'h12345678);
    step();

    // Periodic refresh with row 0x0013 open
    n = 0;
    while (bus.host_busy !== 1'b1 && n < 900) begin
      step();
      n++;
    end
    chk("t4_refresh_seen", {31'h0, bus.host_busy}, 32'h1);
    b_cyc = cyc;
    ack0 = n_ack;
    k = 0; pk = -1; rk = -1;
    while (bus.host_busy === 1'b1 && k < 40) begin
      if (bus.sd_pch === 1'b1) pk = k;
      if (bus.sd_ref === 1'b1) rk = k;
      bus.host_req  = (k == 6);
      bus.host_rnw  = 1'b1;
      bus.host_addr = {13'h0044, 9'h001};
      step();
      k++;
    end
    bus.host_req = 1'b0;
    chk("t4_busy_len", k, 32'd14);
    chk("t4_pch_at", pk, 32'd1);
    chk("t4_ref_at", rk, 32'd4);
    issue(1'b1, {13'h0013, 9'h010}, 32'h0, 4'hF);
    chk("t4_closed_act", {31'h0, bus.sd_act}, 32'h1);
    chk("t4_closed_row", {19'h0, bus.sd_caddr}, 32'h0013);
    steps(3);
    complete(32'h55AA55AA);
    chk("t4_dout", bus.host_dout, 32'h55AA55AA);
    step();
    chk("t4_one_ack", n_ack - ack0, 32'd1);

    // Request in the cycle the next refresh falls due
    while (cyc < b_cyc + 779) step();
    ack0 = n_ack;
    issue(1'b1, {13'h0013, 9'h020}, 32'h0, 4'hF);
    chk("t5_busy", {31'h0, bus.host_busy}, 32'h1);
    chk("t5_no_hit", pulses_s, 32'h0);
    step();
    chk("t5_pch", {31'h0, bus.sd_pch}, 32'h1);
    steps(3);
    chk("t5_ref", {31'h0, bus.sd_ref}, 32'h1);
    steps(2);
    bus.host_req  = 1'b1;
    bus.host_addr = {13'h0077, 9'h002};
    step();
    bus.host_req  = 1'b0;
    steps(7);
    chk("t5_act", {31'h0, bus.sd_act}, 32'h1);
    chk("t5_act_row", {19'h0, bus.sd_caddr}, 32'h0013);
    steps(3);
    chk("t5_req", {31'h0, bus.sd_req}, 32'h1);
    chk("t5_col", {19'h0, bus.sd_caddr}, 32'h0020);
    complete(32'hA5A55A5A);
    chk("t5_ack", {31'h0, bus.host_ack}, 32'h1);
    chk("t5_dout", bus.host_dout, 32'hA5A55A5A);
    steps(4);
    chk("t5_one_ack", n_ack - ack0, 32'd1);

    // init during ACCESS, late sd_ready
    ack0 = n_ack;
    issue(1'b1, {13'h0013, 9'h007}, 32'h0, 4'hF);
    chk("t6_hit", {31'h0, bus.sd_req}, 32'h1);
    init = 1'b1;
    step();
    init = 1'b0;
    bus.sd_dout  = 32'h99999999;
    bus.sd_ready = 1'b1;
    step();
    bus.sd_ready = 1'b0;
    steps(2);
    chk("t6_no_ack", n_ack - ack0, 32'd0);
    chk("t6_busy", {31'h0, bus.host_busy}, 32'h0);
    chk("t6_dout", bus.host_dout, 32'h0);
    chk("t6_caddr", {19'h0, bus.sd_caddr}, 32'h0);
    chk("t6_attr", {bus.sd_din[27:0], bus.sd_be}, 32'h0);
    chk("t6_rnw", {31'h0, bus.sd_rnw}, 32'h0);
    issue(1'b1, {13'h0013, 9'h008}, 32'h0, 4'hF);
    chk("t6_row_closed", {31'h0, bus.sd_act}, 32'h1);
    steps(3);
    complete(32'h0BADF00D);
    chk("t6_dout2", bus.host_dout, 32'h0BADF00D);
    step();

    chk("cmd_spacing", viol, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
